// File: rtl/ex_opnd_stage_pkg.sv
// Shared types for the execute-stage operand unit: opcodes, operand-source
// selectors and the per-opcode select helpers.
package ex_opnd_stage_pkg;

    localparam int NUM_FWD_DEFAULT = 3;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_MEM   = 7'b0001111,
        OP_I     = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_STORE = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_LUI   = 7'b0110111,
        OP_B     = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111,
        OP_SYS   = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        OPND_NULL,
        OPND_RS,
        OPND_PC,
        OPND_IMM
    } opnd_sel_t;

    function automatic opnd_sel_t a_sel(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_B, OP_LOAD, OP_STORE: a_sel = OPND_RS;
            OP_AUIPC, OP_JAL, OP_JALR:           a_sel = OPND_PC;
            default:                             a_sel = OPND_NULL;
        endcase
    endfunction

    function automatic opnd_sel_t b_sel(input logic [6:0] op);
        case (op)
            OP_R, OP_B:                                   b_sel = OPND_RS;
            OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_STORE:                            b_sel = OPND_IMM;
            default:                                      b_sel = OPND_NULL;
        endcase
    endfunction

endpackage

// File: rtl/ex_opnd_stage_fwd_resolve.sv
// Combinational priority search of one source register against the
// forwarding sources; the lowest-index match decides, even if it is pending.
module fwd_resolve
    import ex_opnd_stage_pkg::*;
#(
    parameter int NUM_FWD = NUM_FWD_DEFAULT,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5
) (
    input  logic [REG_AW-1:0]              addr,
    input  logic [XLEN-1:0]                reg_val,
    input  logic [NUM_FWD-1:0]             fwd_valid,
    input  logic [NUM_FWD-1:0]             fwd_pending,
    input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]                val,
    output logic                           resolved
);

    logic hit;

    always_comb begin
        val      = reg_val;
        resolved = 1'b1;
        hit      = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_valid[i] && fwd_rd[i] == addr) begin
                hit      = 1'b1;
                resolved = !fwd_pending[i];
                val      = fwd_data[i];
            end
        end
        if (addr == '0) begin
            val      = '0;
            resolved = 1'b1;
        end
    end

endmodule

// File: rtl/ex_opnd_stage.sv
// Execute-stage operand unit: one-entry holding register that resolves
// rs1/rs2 through the forwarding network and selects ALU operands.
module ex_opnd_stage
    import ex_opnd_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = NUM_FWD_DEFAULT,
    parameter int REG_AW  = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [6:0]                     in_opcode,
    input  logic [XLEN-1:0]                in_pc,
    input  logic [XLEN-1:0]                in_rs1,
    input  logic [XLEN-1:0]                in_rs2,
    input  logic [XLEN-1:0]                in_imm,
    input  logic [REG_AW-1:0]              in_rs1_addr,
    input  logic [REG_AW-1:0]              in_rs2_addr,
    input  logic [NUM_FWD-1:0]             fwd_valid,
    input  logic [NUM_FWD-1:0]             fwd_pending,
    input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                a_out,
    output logic [XLEN-1:0]                b_out,
    output logic [XLEN-1:0]                store_data,
    output logic [15:0]                    stall_cnt
);

    logic              held;
    logic [6:0]        op_q;
    logic [XLEN-1:0]   pc_q, imm_q, rs1_val, rs2_val;
    logic [REG_AW-1:0] rs1_addr, rs2_addr;
    logic              rs1_ok, rs2_ok;

    logic              accept, consume;
    logic [REG_AW-1:0] r1_addr, r2_addr;
    logic [XLEN-1:0]   r1_reg, r2_reg, r1_val, r2_val;
    logic              r1_ok, r2_ok;

    assign out_valid = held & rs1_ok & rs2_ok;
    assign in_ready  = !held | (out_valid & out_ready);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // While an operand is unresolved its value register still holds the
    // regfile read, so it doubles as the fallback when no source matches.
    assign r1_addr = accept ? in_rs1_addr : rs1_addr;
    assign r2_addr = accept ? in_rs2_addr : rs2_addr;
    assign r1_reg  = accept ? in_rs1      : rs1_val;
    assign r2_reg  = accept ? in_rs2      : rs2_val;

    fwd_resolve #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .REG_AW(REG_AW)) u_res1 (
        .addr(r1_addr), .reg_val(r1_reg), .fwd_valid(fwd_valid),
        .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .val(r1_val), .resolved(r1_ok)
    );

    fwd_resolve #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .REG_AW(REG_AW)) u_res2 (
        .addr(r2_addr), .reg_val(r2_reg), .fwd_valid(fwd_valid),
        .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .val(r2_val), .resolved(r2_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held     <= 1'b0;
            op_q     <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            rs1_val  <= '0;
            rs2_val  <= '0;
            rs1_ok   <= 1'b1;
            rs2_ok   <= 1'b1;
        end else if (flush) begin
            held <= 1'b0;
        end else if (accept) begin
            held     <= 1'b1;
            op_q     <= in_opcode;
            pc_q     <= in_pc;
            imm_q    <= in_imm;
            rs1_addr <= in_rs1_addr;
            rs2_addr <= in_rs2_addr;
            rs1_ok   <= r1_ok;
            rs2_ok   <= r2_ok;
            rs1_val  <= r1_ok ? r1_val : in_rs1;
            rs2_val  <= r2_ok ? r2_val : in_rs2;
        end else if (consume) begin
            held <= 1'b0;
        end else if (held) begin
            // Resolved operands are frozen; only chase the unresolved ones.
            if (!rs1_ok && r1_ok) begin
                rs1_ok  <= 1'b1;
                rs1_val <= r1_val;
            end
            if (!rs2_ok && r2_ok) begin
                rs2_ok  <= 1'b1;
                rs2_val <= r2_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (held && !out_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    always_comb begin
        a_out      = '0;
        b_out      = '0;
        store_data = '0;
        if (out_valid) begin
            case (a_sel(op_q))
                OPND_RS:  a_out = rs1_val;
                OPND_PC:  a_out = pc_q;
                OPND_IMM: a_out = imm_q;
                default:  a_out = '0;
            endcase
            case (b_sel(op_q))
                OPND_RS:  b_out = rs2_val;
                OPND_PC:  b_out = pc_q;
                OPND_IMM: b_out = imm_q;
                default:  b_out = '0;
            endcase
            store_data = rs2_val;
        end
    end

endmodule

// File: tb/tb_ex_opnd_stage.sv
// Bench for ex_opnd_stage: streamed vector table with a scoreboard, plus
// load-use, fallback, flush and reset sequences.
module tb_ex_opnd_stage;
    import ex_opnd_stage_pkg::*;

    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam int AW   = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [6:0]             in_opcode;
    logic [XLEN-1:0]        in_pc, in_rs1, in_rs2, in_imm;
    logic [AW-1:0]          in_rs1_addr, in_rs2_addr;
    logic [NF-1:0]          fwd_valid, fwd_pending;
    logic [NF-1:0][AW-1:0]  fwd_rd;
    logic [NF-1:0][XLEN-1:0] fwd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        a_out, b_out, store_data;
    logic [15:0]            stall_cnt;

    ex_opnd_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .store_data(store_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]              op;
        logic [XLEN-1:0]         pc, rs1, rs2, imm;
        logic [AW-1:0]           a1, a2;
        logic [NF-1:0]           fv;
        logic [NF-1:0][AW-1:0]   frd;
        logic [NF-1:0][XLEN-1:0] fd;
        logic [XLEN-1:0]         ea, eb, es;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] a, b, s;
    } exp_t;

    localparam int NV = 15;
    vec_t tbl[NV];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic [31:0] pc, rs1, rs2, imm,
                                input logic [4:0] a1, a2, input logic [31:0] ea, eb, es);
        vec_t v;
        v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.a1 = a1; v.a2 = a2; v.fv = '0; v.frd = '0; v.fd = '0;
        v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        flush       = 1'b0;
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_rd      = '0;
        fwd_data    = '0;
    endtask

    task automatic drive(input vec_t v, input bit push);
        in_opcode   = v.op;   in_pc  = v.pc;   in_imm = v.imm;
        in_rs1      = v.rs1;  in_rs2 = v.rs2;
        in_rs1_addr = v.a1;   in_rs2_addr = v.a2;
        fwd_valid   = v.fv;   fwd_rd = v.frd;  fwd_data = v.fd;
        fwd_pending = '0;
        in_valid    = 1'b1;
        if (push) sb.push_back('{v.ea, v.eb, v.es});
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_scoreboard got output want none", tag);
            end else begin
                e = sb.pop_front();
                check({tag, "_a"}, a_out, e.a);
                check({tag, "_b"}, b_out, e.b);
                check({tag, "_sd"}, store_data, e.s);
            end
        end
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(OP_R,     32'h0,   32'd10,   32'd20,  32'h0,        5'd5,  5'd6,  32'd10,   32'd20,       32'd20);
        tbl[1]  = mk(OP_R,     32'h0,   32'd1,    32'd2,   32'h0,        5'd5,  5'd6,  32'hAA,   32'd2,        32'd2);
        tbl[1].fv = 3'b101; tbl[1].frd[0] = 5'd5; tbl[1].fd[0] = 32'hAA;
        tbl[1].frd[2] = 5'd5; tbl[1].fd[2] = 32'hBB;
        tbl[2]  = mk(OP_AUIPC, 32'h100, 32'd3,    32'd4,   32'h2000,     5'd0,  5'd0,  32'h100,  32'h2000,     32'd0);
        tbl[2].fv = 3'b001; tbl[2].frd[0] = 5'd0; tbl[2].fd[0] = 32'd5;
        tbl[3]  = mk(OP_R,     32'h0,   32'd77,   32'd88,  32'h0,        5'd0,  5'd11, 32'd0,    32'd88,       32'd88);
        tbl[3].fv = 3'b001; tbl[3].frd[0] = 5'd0; tbl[3].fd[0] = 32'd5;
        tbl[4]  = mk(OP_LUI,   32'h0,   32'd1,    32'd2,   32'h12345000, 5'd1,  5'd2,  32'd0,    32'h12345000, 32'd2);
        tbl[5]  = mk(OP_STORE, 32'h0,   32'h1000, 32'h55,  32'd8,        5'd3,  5'd4,  32'h1000, 32'd8,        32'h55);
        tbl[6]  = mk(OP_SYS,   32'h0,   32'd9,    32'd7,   32'd1,        5'd1,  5'd2,  32'd0,    32'd0,        32'd7);
        tbl[7]  = mk(OP_B,     32'h0,   32'd30,   32'd40,  32'd12,       5'd12, 5'd13, 32'd30,   32'd40,       32'd40);
        tbl[8]  = mk(OP_R,     32'h0,   32'd1,    32'd2,   32'h0,        5'd3,  5'd9,  32'd1,    32'h11,       32'h11);
        tbl[8].fv = 3'b110; tbl[8].frd[1] = 5'd9; tbl[8].fd[1] = 32'h11;
        tbl[8].frd[2] = 5'd9; tbl[8].fd[2] = 32'h22;
        tbl[9]  = mk(7'h7F,    32'h50,  32'd5,    32'd6,   32'd9,        5'd1,  5'd2,  32'd0,    32'd0,        32'd6);
        tbl[10] = mk(OP_JAL,   32'h400, 32'd1,    32'd2,   32'h10,       5'd1,  5'd2,  32'h400,  32'h10,       32'd2);
        tbl[11] = mk(OP_LOAD,  32'h0,   32'h2000, 32'd3,   32'd4,        5'd14, 5'd15, 32'h2000, 32'd4,        32'd3);
        tbl[12] = mk(OP_MEM,   32'h8,   32'd1,    32'd2,   32'd3,        5'd1,  5'd2,  32'd0,    32'd0,        32'd2);
        tbl[13] = mk(OP_I,     32'h0,   32'd50,   32'd4,   32'd7,        5'd1,  5'd2,  32'd50,   32'd7,        32'd4);
        tbl[14] = mk(OP_JALR,  32'h600, 32'd1,    32'd9,   32'd3,        5'd1,  5'd2,  32'h600,  32'd3,        32'd9);

        rst_n = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_rs1_addr = '0; in_rs2_addr = '0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_a", a_out, 32'd0);
        check("rst_b", b_out, 32'd0);
        check("rst_sd", store_data, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        // Streamed table: one instruction per cycle, output must follow with no bubble.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_out($sformatf("vec%0d", i - 1));
                check($sformatf("vec%0d_in_ready", i - 1), {31'd0, in_ready}, 32'd1);
            end
            drive(tbl[i], 1'b1);
        end
        @(negedge clk);
        check_out($sformatf("vec%0d", NV - 1));
        idle();
        @(negedge clk);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_sb_empty", sb.size(), 32'd0);
        check("stream_stall", {16'd0, stall_cnt}, 32'd0);

        // Load-use: fwd[1] pending on x7 for three sampling edges.
        v = mk(OP_R, 32'h0, 32'h999, 32'd0, 32'h0, 5'd7, 5'd0, 32'h1234, 32'd0, 32'd0);
        v.fv = 3'b010; v.frd[1] = 5'd7; v.fd[1] = 32'hDEAD;
        drive(v, 1'b1);
        fwd_pending = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("lu_wait%0d_out_valid", c), {31'd0, out_valid}, 32'd0);
            check($sformatf("lu_wait%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        fwd_pending = 3'b000; fwd_data[1] = 32'h1234;
        @(negedge clk);
        check_out("lu");
        check("lu_stall", {16'd0, stall_cnt}, 32'd3);
        idle();

        // Pending source drops out: falls back to fwd[1]; resolved rs2 stays frozen.
        v = mk(OP_R, 32'h0, 32'h808, 32'h90, 32'h0, 5'd8, 5'd9, 32'h31, 32'h90, 32'h90);
        v.fv = 3'b011; v.frd[0] = 5'd8; v.fd[0] = 32'hBAD; v.frd[1] = 5'd8; v.fd[1] = 32'h31;
        drive(v, 1'b1);
        fwd_pending = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        check("fb_wait_out_valid", {31'd0, out_valid}, 32'd0);
        fwd_valid = 3'b110; fwd_rd[2] = 5'd9; fwd_data[2] = 32'hDEAD;
        @(negedge clk);
        check_out("fb");
        check("fb_stall", {16'd0, stall_cnt}, 32'd4);
        idle();

        // Flush while a pending hit is held.
        v = mk(OP_R, 32'h0, 32'h1, 32'h2, 32'h0, 5'd7, 5'd2, 32'h0, 32'h0, 32'h0);
        v.fv = 3'b001; v.frd[0] = 5'd7;
        drive(v, 1'b0);
        fwd_pending = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        check("fl_hold_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fwd_valid = '0; fwd_pending = '0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush overrides a same-cycle accept.
        drive(tbl[0], 1'b0);
        flush = 1'b1;
        check("fl_acc_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        idle();
        check("fl_acc_dropped", {31'd0, out_valid}, 32'd0);

        drive(tbl[7], 1'b1);
        @(negedge clk);
        idle();
        check_out("post_flush");
        @(negedge clk);

        // Reset pulse mid-hold clears the entry and the stall counter.
        drive(v, 1'b0);
        fwd_pending = 3'b001;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hold_stall", {16'd0, stall_cnt}, 32'd0);
        check("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        drive(tbl[5], 1'b1);
        @(negedge clk);
        idle();
        check_out("post_rst");
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
